// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider: state encoding,
// default width and the packed result layout.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_FIX  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  // Result bus is {quotient, remainder}
  localparam int QUO_LSB = DIV_WIDTH;
  localparam int REM_LSB = 0;

  localparam logic [DIV_WIDTH-1:0] DZ_QUO = '1;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring division step: shift {rem,quo} left, subtract the divisor
// from the partial remainder and keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           fits;

  // Compare as an unsigned magnitude so a zero divisor (rem not bounded by
  // the divisor) still reads as "fits" on every step.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, divisor};
  assign fits   = rem_sh >= {1'b0, divisor};

  assign rem_next = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider with a dual-channel operand stream,
// sign fix-up stage and synchronous flush; result latency is WIDTH+2 cycles.
module div_radix2
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix;
  logic [CW-1:0]    cnt;
  logic             qneg, rneg, dz;
  logic             accept, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept = (state == S_IDLE || state == S_DONE) && s_axis_dividend_tvalid &&
                  s_axis_divisor_tvalid && !flush && !reset;
  assign s_axis_dividend_tready = accept;
  assign s_axis_divisor_tready  = accept;

  // WIDTH-bit two's-complement negate keeps |min_int| as an unsigned magnitude.
  assign a_neg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
  assign b_neg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
  assign a_mag = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign b_mag = b_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Negating the remainder of a zero divide restores the raw dividend.
  always_comb begin
    quo_fix = dz ? {WIDTH{1'b1}} : (qneg ? -quo : quo);
    rem_fix = rneg ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state              <= S_IDLE;
      rem                <= '0;
      quo                <= '0;
      dvsr               <= '0;
      cnt                <= '0;
      qneg               <= 1'b0;
      rneg               <= 1'b0;
      dz                 <= 1'b0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tvalid <= 1'b0;
    end else if (accept) begin
      state              <= S_BUSY;
      rem                <= '0;
      quo                <= a_mag;
      dvsr               <= b_mag;
      cnt                <= '0;
      qneg               <= a_neg ^ b_neg;
      rneg               <= a_neg;
      dz                 <= (s_axis_divisor_tdata == '0);
      m_axis_dout_tvalid <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          m_axis_dout_tdata  <= {quo_fix, rem_fix};
          m_axis_dout_tvalid <= 1'b1;
          state              <= S_DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench: unsigned and signed dividers share stimulus and are
// compared against an arithmetic reference of truncating division.
module tb_div_radix2;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic clk = 1'b0;
  logic reset, flush;
  logic [W-1:0] a, b;
  logic av, bv;
  logic ar0, br0, ar1, br1, v0, v1;
  logic [2*W-1:0] d0, d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_radix2 #(.WIDTH(W), .SIGNED(1'b0)) u_div_u (
    .clk(clk), .reset(reset), .flush(flush),
    .s_axis_dividend_tdata(a), .s_axis_dividend_tvalid(av), .s_axis_dividend_tready(ar0),
    .s_axis_divisor_tdata(b), .s_axis_divisor_tvalid(bv), .s_axis_divisor_tready(br0),
    .m_axis_dout_tdata(d0), .m_axis_dout_tvalid(v0)
  );

  div_radix2 #(.WIDTH(W), .SIGNED(1'b1)) u_div_s (
    .clk(clk), .reset(reset), .flush(flush),
    .s_axis_dividend_tdata(a), .s_axis_dividend_tvalid(av), .s_axis_dividend_tready(ar1),
    .s_axis_divisor_tdata(b), .s_axis_divisor_tvalid(bv), .s_axis_divisor_tready(br1),
    .m_axis_dout_tdata(d1), .m_axis_dout_tvalid(v1)
  );

  // Reference: plain truncating division; remainder follows the dividend.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input bit sg);
    longint sx, sy, q, r;
    logic [W-1:0] uq, ur;
    if (y == 0) return {DZ_QUO, x};
    if (!sg) begin
      uq = x / y;
      ur = x % y;
      return {uq, ur};
    end
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    q  = sx / sy;
    r  = sx % sy;
    return {q[W-1:0], r[W-1:0]};
  endfunction

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, output logic rdy);
    @(negedge clk);
    a = x; b = y; av = 1'b1; bv = 1'b1;
    #1 rdy = ar0 & br0 & ar1 & br1;
    @(posedge clk);
    #1 av = 1'b0; bv = 1'b0;
  endtask

  task automatic wait_result(output bit got, output int lat,
                             output logic [2*W-1:0] r0, output logic [2*W-1:0] r1);
    got = 1'b0; lat = 0; r0 = '0; r1 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (v0 || v1) begin
        got = 1'b1; lat = c; r0 = d0; r1 = d1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; a = 32'd5; b = 32'd1; av = 1'b1; bv = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ar0, br0, ar1, br1} !== 4'b0) begin
      errors++; $display("FAIL reset_tready got=%b want=0000", {ar0, br0, ar1, br1});
    end
    checks++;
    if ({v0, v1} !== 2'b00 || d0 !== '0 || d1 !== '0) begin
      errors++; $display("FAIL reset_dout got v=%b d0=%h d1=%h want 0", {v0, v1}, d0, d1);
    end
    reset = 1'b0; av = 1'b0; bv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic rdy;
    bit busy_bad, got;
    int lat;
    logic [2*W-1:0] r0, r1;
    issue(32'd100, 32'd7, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL basic_accept got=%b want=1", rdy); end
    busy_bad = 1'b0;
    av = 1'b1; bv = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      #1 if ({ar0, br0, ar1, br1, v0, v1} !== 6'b0) busy_bad = 1'b1;
    end
    av = 1'b0; bv = 1'b0;
    checks++;
    if (busy_bad) begin errors++; $display("FAIL basic_busy got=ready/valid high want=low"); end
    wait_result(got, lat, r0, r1);
    lat += 33;
    checks++;
    if (!got || lat != 34) begin
      errors++; $display("FAIL basic_latency got=%0d want=34", got ? lat : -1);
    end
    checks++;
    if (r0 !== {32'd14, 32'd2} || r1 !== {32'd14, 32'd2}) begin
      errors++; $display("FAIL basic_data got=%h/%h want=%h", r0, r1, {32'd14, 32'd2});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] xs [6] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000, 32'h12345678, 32'd0};
    logic [W-1:0] ys [6] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd9};
    logic rdy;
    bit got;
    int lat;
    logic [2*W-1:0] r0, r1;
    for (int i = 0; i < 6; i++) begin
      issue(xs[i], ys[i], rdy);
      wait_result(got, lat, r0, r1);
      checks++;
      if (rdy !== 1'b1 || !got || lat != 34) begin
        errors++; $display("FAIL dir%0d_timing rdy=%b lat=%0d want rdy=1 lat=34", i, rdy, got ? lat : -1);
      end
      checks++;
      if (r0 !== ref_div(xs[i], ys[i], 1'b0)) begin
        errors++; $display("FAIL dir%0d_unsigned got=%h want=%h", i, r0, ref_div(xs[i], ys[i], 1'b0));
      end
      checks++;
      if (r1 !== ref_div(xs[i], ys[i], 1'b1)) begin
        errors++; $display("FAIL dir%0d_signed got=%h want=%h", i, r1, ref_div(xs[i], ys[i], 1'b1));
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic rdy;
    bit got;
    int lat;
    logic [2*W-1:0] r0, r1;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      case (i % 4)
        0: y = $urandom;
        1: y = $urandom_range(1, 20);
        2: y = -$urandom_range(1, 20);
        default: y = (i % 8 == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      issue(x, y, rdy);
      wait_result(got, lat, r0, r1);
      checks++;
      if (rdy !== 1'b1 || !got || lat != 34 || r0 !== ref_div(x, y, 1'b0) ||
          r1 !== ref_div(x, y, 1'b1)) begin
        errors++;
        $display("FAIL rand%0d %h/%h lat=%0d got=%h/%h want=%h/%h", i, x, y, got ? lat : -1,
                 r0, r1, ref_div(x, y, 1'b0), ref_div(x, y, 1'b1));
      end
    end
  endtask

  task automatic test_abort(input bit by_reset);
    logic rdy;
    bit got;
    int lat;
    logic [2*W-1:0] r0, r1;
    issue(32'd1000, 32'd3, rdy);
    repeat (9) @(negedge clk);
    @(negedge clk);
    a = 32'hFFFFFF9C; b = 32'd9; av = 1'b1; bv = 1'b1;
    if (by_reset) reset = 1'b1; else flush = 1'b1;
    #1;
    checks++;
    if ({ar0, br0, ar1, br1} !== 4'b0) begin
      errors++; $display("FAIL abort%0d_ready_blocked got=%b want=0000", by_reset, {ar0, br0, ar1, br1});
    end
    @(negedge clk);
    reset = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if ({ar0, br0, ar1, br1} !== 4'b1111 || {v0, v1} !== 2'b00 || d0 !== '0 || d1 !== '0) begin
      errors++;
      $display("FAIL abort%0d_cycle11 rdy=%b v=%b d0=%h d1=%h want rdy=1111 v=00 d=0",
               by_reset, {ar0, br0, ar1, br1}, {v0, v1}, d0, d1);
    end
    @(posedge clk);
    #1 av = 1'b0; bv = 1'b0;
    wait_result(got, lat, r0, r1);
    checks++;
    if (!got || lat != 34 || r0 !== ref_div(32'hFFFFFF9C, 32'd9, 1'b0) ||
        r1 !== ref_div(32'hFFFFFF9C, 32'd9, 1'b1)) begin
      errors++;
      $display("FAIL abort%0d_next lat=%0d got=%h/%h want=%h/%h", by_reset, got ? lat : -1, r0, r1,
               ref_div(32'hFFFFFF9C, 32'd9, 1'b0), ref_div(32'hFFFFFF9C, 32'd9, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic rdy;
    bit got, held_bad;
    int lat;
    logic [2*W-1:0] r0, r1;
    issue(32'd100, 32'd7, rdy);
    wait_result(got, lat, r0, r1);
    held_bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (v0 !== 1'b1 || d0 !== {32'd14, 32'd2}) held_bad = 1'b1;
    end
    checks++;
    if (!got || lat != 34 || held_bad) begin
      errors++; $display("FAIL b2b_hold lat=%0d d0=%h want lat=34 held %h", got ? lat : -1, d0, {32'd14, 32'd2});
    end
    issue(32'd9, 32'd4, rdy);
    #1;
    checks++;
    if (rdy !== 1'b1 || v0 !== 1'b0) begin
      errors++; $display("FAIL b2b_accept rdy=%b v_after=%b want rdy=1 v_after=0", rdy, v0);
    end
    wait_result(got, lat, r0, r1);
    checks++;
    if (!got || lat != 34 || r0 !== {32'd2, 32'd1} || r1 !== {32'd2, 32'd1}) begin
      errors++; $display("FAIL b2b_second lat=%0d got=%h/%h want 34 %h", got ? lat : -1, r0, r1, {32'd2, 32'd1});
    end
  endtask

  task automatic test_lone_valid();
    bit bad;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a = 32'd50; b = 32'd5;
      av = (c < 5); bv = (c >= 5);
      #1 if ({ar0, br0, ar1, br1} !== 4'b0) bad = 1'b1;
    end
    @(negedge clk);
    av = 1'b0; bv = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL lone_valid_ready got=high want=0"); end
    checks++;
    if (v0 !== 1'b1 || d0[QUO_LSB +: W] !== 32'd2 || d0[REM_LSB +: W] !== 32'd1) begin
      errors++; $display("FAIL lone_valid_result v=%b d0=%h want v=1 %h", v0, d0, {32'd2, 32'd1});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    test_lone_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
